// File: rtl/csr_file.sv
// csr_file: machine-mode CSR block for a single-hart RV32 core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause, the mcycle/minstret counters,
// read-only misa/mhartid/mip, trap-entry and MRET side effects, and the
// interrupt-pending summary. Reads are combinational; updates land on the
// next rising edge of i_clk.
// Optional machine timer (mtime/mtimecmp/MTIP) is built when CSR_TIMER_EN is
// defined; otherwise 7C0-7C3 decode as unmapped and MTIP is tied low.
module csr_file #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] HARTID    = '0,
  parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter int unsigned     MTIME_DIV = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_en,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_instret,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic            i_mret,
  input  logic            i_ext_intr,
  input  logic            i_sw_intr,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_intr_pending
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MTIME     = 12'h7C0;
  localparam logic [11:0] A_MTIMEH    = 12'h7C1;
  localparam logic [11:0] A_MTIMECMP  = 12'h7C2;
  localparam logic [11:0] A_MTIMECMPH = 12'h7C3;

  localparam logic [XLEN-1:0]   ALIGN_MASK = ~XLEN'(3);
  localparam logic [2*XLEN-1:0] CNT_ONE    = (2*XLEN)'(1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("csr_file: only XLEN=32 is supported");
  end
  if (MTIME_DIV < 1 || MTIME_DIV > 255) begin : g_bad_div
    $error("csr_file: MTIME_DIV must be in 1..255");
  end

  // architectural state
  logic              mstatus_mie_q, mstatus_mie_d;
  logic              mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]        mie_q, mie_d;          // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [2*XLEN-1:0] mcycle_q, mcycle_d;
  logic [2*XLEN-1:0] minstret_q, minstret_d;
  logic              mtip;

`ifdef CSR_TIMER_EN
  localparam logic [7:0] PRESC_MAX = 8'(MTIME_DIV - 1);
  logic [2*XLEN-1:0] mtime_q, mtime_d;
  logic [2*XLEN-1:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]        presc_q, presc_d;
`endif

  // decoded request
  csr_op_e         op;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] wval;
  logic            mapped;
  logic            wr_en;
  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;

  assign op = csr_op_e'(i_csr_op);

  // assemble the architecturally visible views of the packed registers
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mstatus_mpie_q;
    mstatus_rd[3]     = mstatus_mie_q;
    mie_rd            = '0;
    mie_rd[11]        = mie_q[2];
    mie_rd[7]         = mie_q[1];
    mie_rd[3]         = mie_q[0];
    mip_rd            = '0;
    mip_rd[11]        = i_ext_intr;
    mip_rd[7]         = mtip;
    mip_rd[3]         = i_sw_intr;
  end

  // address decode and read mux
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (i_csr_addr)
      A_MSTATUS:   rd_val = mstatus_rd;
      A_MISA:      rd_val = MISA_VAL;
      A_MIE:       rd_val = mie_rd;
      A_MTVEC:     rd_val = mtvec_q;
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MIP:       rd_val = mip_rd;
      A_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
      A_MCYCLEH:   rd_val = mcycle_q[2*XLEN-1:XLEN];
      A_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
      A_MINSTRETH: rd_val = minstret_q[2*XLEN-1:XLEN];
      A_MHARTID:   rd_val = HARTID;
`ifdef CSR_TIMER_EN
      A_MTIME:     rd_val = mtime_q[XLEN-1:0];
      A_MTIMEH:    rd_val = mtime_q[2*XLEN-1:XLEN];
      A_MTIMECMP:  rd_val = mtimecmp_q[XLEN-1:0];
      A_MTIMECMPH: rd_val = mtimecmp_q[2*XLEN-1:XLEN];
`endif
      default:     mapped = 1'b0;
    endcase
  end

  // write/set/clear value formed from the pre-write read value
  always_comb begin
    case (op)
      OP_WRITE: wval = i_csr_wdata;
      OP_SET:   wval = rd_val | i_csr_wdata;
      OP_CLEAR: wval = rd_val & ~i_csr_wdata;
      default:  wval = rd_val;
    endcase
    wr_en = i_csr_en && (op != OP_NONE) && mapped;
  end

  // next-state for core CSRs and counters
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + CNT_ONE;
    minstret_d     = minstret_q + {{(2*XLEN-1){1'b0}}, i_instret};
    if (wr_en) begin
      case (i_csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:       mie_d      = {wval[11], wval[7], wval[3]};
        A_MTVEC:     mtvec_d    = wval & ALIGN_MASK;
        A_MSCRATCH:  mscratch_d = wval;
        A_MEPC:      mepc_d     = wval & ALIGN_MASK;
        A_MCAUSE:    mcause_d   = wval;
        A_MCYCLE:    mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], wval};
        A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[XLEN-1:0]};
        A_MINSTRET:  minstret_d = {minstret_q[2*XLEN-1:XLEN], wval};
        A_MINSTRETH: minstret_d = {wval, minstret_q[XLEN-1:0]};
        default: ;
      endcase
    end
    // Later assignments win: trap over MRET over CSR write, per field only.
    if (i_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
    if (i_trap) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = i_trap_pc & ALIGN_MASK;
      mcause_d       = i_trap_cause;
    end
  end

  // core CSR and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

`ifdef CSR_TIMER_EN
  // prescaled mtime tick, CSR writes to timer halves override the tick
  always_comb begin
    presc_d    = presc_q + 8'd1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      mtime_d = mtime_q + CNT_ONE;
    end
    if (wr_en) begin
      case (i_csr_addr)
        A_MTIME:     mtime_d    = {mtime_q[2*XLEN-1:XLEN], wval};
        A_MTIMEH:    mtime_d    = {wval, mtime_q[XLEN-1:0]};
        A_MTIMECMP:  mtimecmp_d = {mtimecmp_q[2*XLEN-1:XLEN], wval};
        A_MTIMECMPH: mtimecmp_d = {wval, mtimecmp_q[XLEN-1:0]};
        default: ;
      endcase
    end
  end

  // timer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtip = (mtime_q >= mtimecmp_q);
`else
  assign mtip = 1'b0;
`endif

  assign o_csr_rdata    = rd_val;
  assign o_csr_illegal  = i_csr_en & ~mapped;
  assign o_mtvec        = mtvec_q;
  assign o_mepc         = mepc_q;
  assign o_intr_pending = mstatus_mie_q & |(mip_rd & mie_rd);

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard bench for csr_file. Expected values are queued as
// stimulus is applied and compared once the combinational outputs settle.
// Timer checks are built when CSR_TIMER_EN is defined.
module tb_csr_file;

  localparam logic [31:0] HARTID_P    = 32'd5;
  localparam logic [31:0] MISA_P      = 32'h4000_0100;
  localparam logic [31:0] MTVEC_RST_P = 32'h0000_1000;
  localparam logic [1:0]  W = 2'b01;
  localparam logic [1:0]  S = 2'b10;
  localparam logic [1:0]  C = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret, trap, mret, ext_intr, sw_intr;
  logic [31:0] trap_pc, trap_cause;
  logic [31:0] mtvec, mepc;
  logic        intr_pending;

  csr_file #(
    .XLEN      (32),
    .HARTID    (HARTID_P),
    .MISA_VAL  (MISA_P),
    .MTVEC_RST (MTVEC_RST_P),
    .MTIME_DIV (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_csr_en       (csr_en),
    .i_csr_op       (csr_op),
    .i_csr_addr     (csr_addr),
    .i_csr_wdata    (csr_wdata),
    .o_csr_rdata    (csr_rdata),
    .o_csr_illegal  (csr_illegal),
    .i_instret      (instret),
    .i_trap         (trap),
    .i_trap_pc      (trap_pc),
    .i_trap_cause   (trap_cause),
    .i_mret         (mret),
    .i_ext_intr     (ext_intr),
    .i_sw_intr      (sw_intr),
    .o_mtvec        (mtvec),
    .o_mepc         (mepc),
    .o_intr_pending (intr_pending)
  );

  always #50 clk = ~clk;

  typedef enum int {K_RDATA, K_ILLEGAL, K_PENDING, K_MEPC, K_MTVEC} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] mask;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input kind_e kind, input logic [31:0] mask,
                      input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.kind = kind;
    it.mask = mask;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  // let outputs settle, then retire every queued expectation
  task automatic drain();
    sb_item_t    it;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        K_RDATA:   got = csr_rdata;
        K_ILLEGAL: got = {31'b0, csr_illegal};
        K_PENDING: got = {31'b0, intr_pending};
        K_MEPC:    got = mepc;
        default:   got = mtvec;
      endcase
      check_eq(it.tag, got & it.mask, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] mask,
                    input logic [31:0] exp);
    csr_en   = 1'b1;
    csr_op   = 2'b00;
    csr_addr = addr;
    push(tag, K_RDATA, mask, exp);
    push({tag, "_ill"}, K_ILLEGAL, 32'h1, 32'h0);
    drain();
  endtask

  task automatic rd_illegal(input string tag, input logic [11:0] addr);
    csr_en   = 1'b1;
    csr_op   = 2'b00;
    csr_addr = addr;
    push({tag, "_data"}, K_RDATA, '1, 32'h0);
    push({tag, "_ill"}, K_ILLEGAL, 32'h1, 32'h1);
    drain();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_op    = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    instret = 1'b0; trap = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0;
    ext_intr = 1'b0; sw_intr = 1'b0;
    #10;

    // reset state
    rd("rst_mstatus", 12'h300, '1, 32'h0000_1800);
    rd("rst_misa", 12'h301, '1, MISA_P);
    rd("rst_mtvec", 12'h305, '1, MTVEC_RST_P);
    rd("rst_mhartid", 12'hF14, '1, HARTID_P);
    rd("rst_mcycle", 12'hB00, '1, 32'h0);
    push("rst_o_mepc", K_MEPC, '1, 32'h0);
    push("rst_o_pending", K_PENDING, 32'h1, 32'h0);
    push("rst_o_mtvec", K_MTVEC, '1, MTVEC_RST_P);
    drain();
    rd_illegal("unmapped_123", 12'h123);

    @(negedge clk);
    rst = 1'b0;

`ifdef CSR_TIMER_EN
    wr(W, 12'h7C2, 32'd3);        // edge 1
    wr(W, 12'h7C3, 32'd0);        // edge 2
    wr(W, 12'h304, 32'h80);       // edge 3
    for (int k = 3; k <= 13; k++) begin
      rd($sformatf("mtip_e%0d", k), 12'h344, 32'h80, (k >= 12) ? 32'h80 : 32'h0);
      rd($sformatf("mtime_e%0d", k), 12'h7C0, '1, 32'(k / 4));
      tick();
    end
`else
    rd_illegal("mtime_lo", 12'h7C0);
    rd_illegal("mtime_hi", 12'h7C1);
    rd_illegal("mtimecmp_lo", 12'h7C2);
    rd_illegal("mtimecmp_hi", 12'h7C3);
    wr(W, 12'h7C2, 32'd3);
    rd_illegal("mtimecmp_after_wr", 12'h7C2);
    rd("mip_no_timer", 12'h344, 32'h80, 32'h0);
`endif

    // mtvec alignment, mstatus set/clear and masking, read-only CSRs
    wr(W, 12'h305, 32'h8000_0103);
    rd("mtvec_wr", 12'h305, '1, 32'h8000_0100);
    push("o_mtvec_wr", K_MTVEC, '1, 32'h8000_0100);
    drain();
    wr(S, 12'h300, 32'h8);
    rd("mstatus_set_mie", 12'h300, '1, 32'h0000_1808);
    wr(C, 12'h300, 32'h8);
    rd("mstatus_clr_mie", 12'h300, '1, 32'h0000_1800);
    wr(W, 12'h300, 32'hFFFF_FFFF);
    rd("mstatus_wr_ones", 12'h300, '1, 32'h0000_1888);
    wr(W, 12'h300, 32'h0);
    rd("mstatus_wr_zero", 12'h300, '1, 32'h0000_1800);
    wr(W, 12'h301, 32'h0);
    rd("misa_ro", 12'h301, '1, MISA_P);
    wr(W, 12'hF14, 32'hFFFF_FFFF);
    rd("mhartid_ro", 12'hF14, '1, HARTID_P);
    wr(W, 12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, '1, 32'h0000_0888);

    // interrupt pending
    wr(W, 12'h304, 32'h800);
    wr(S, 12'h300, 32'h8);
    push("pend_ext0", K_PENDING, 32'h1, 32'h0);
    drain();
    ext_intr = 1'b1;
    push("pend_ext1", K_PENDING, 32'h1, 32'h1);
    drain();
    rd("mip_ext", 12'h344, 32'h808, 32'h800);
    ext_intr = 1'b0;
    wr(W, 12'h304, 32'h8);
    sw_intr = 1'b1;
    push("pend_sw1", K_PENDING, 32'h1, 32'h1);
    drain();
    sw_intr = 1'b0;
    push("pend_sw0", K_PENDING, 32'h1, 32'h0);
    drain();

    // trap entry then MRET
    trap = 1'b1; trap_pc = 32'h0000_0123; trap_cause = 32'h8000_000B;
    tick();
    trap = 1'b0;
    rd("trap_mepc", 12'h341, '1, 32'h0000_0120);
    rd("trap_mcause", 12'h342, '1, 32'h8000_000B);
    rd("trap_mstatus", 12'h300, '1, 32'h0000_1880);
    push("trap_o_mepc", K_MEPC, '1, 32'h0000_0120);
    drain();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, '1, 32'h0000_1888);

    // same-cycle priority
    trap = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'd3;
    wr(W, 12'h341, 32'h0000_0ABC);
    trap = 1'b0;
    rd("prio_trap_mepc", 12'h341, '1, 32'h0000_0204);
    rd("prio_trap_mcause", 12'h342, '1, 32'd3);
    rd("prio_trap_mstatus", 12'h300, '1, 32'h0000_1880);
    trap = 1'b1; trap_pc = 32'h0000_0400; trap_cause = 32'd7;
    wr(W, 12'h305, 32'h0000_2000);
    trap = 1'b0;
    rd("prio_trap_mtvec_kept", 12'h305, '1, 32'h0000_2000);
    rd("prio_trap2_mstatus", 12'h300, '1, 32'h0000_1800);
    mret = 1'b1;
    wr(W, 12'h300, 32'h0);
    mret = 1'b0;
    rd("prio_mret_over_wr", 12'h300, '1, 32'h0000_1880);
    trap = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'd2;
    tick();
    trap = 1'b0; mret = 1'b0;
    rd("prio_trap_over_mret", 12'h300, '1, 32'h0000_1800);
    rd("prio_trap_mret_mepc", 12'h341, '1, 32'h0000_0300);

    // mscratch read-modify-write
    wr(W, 12'h340, 32'hA5A5_0000);
    wr(S, 12'h340, 32'h0000_000F);
    wr(C, 12'h340, 32'hA000_0000);
    rd("mscratch_rmw", 12'h340, '1, 32'h05A5_000F);

    // mcycle override and carry
    wr(W, 12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_wr_lo", 12'hB00, '1, 32'hFFFF_FFFF);
    rd("mcycle_wr_hi", 12'hB80, '1, 32'h0);
    tick();
    rd("mcycle_wrap_lo", 12'hB00, '1, 32'h0);
    rd("mcycle_carry_hi", 12'hB80, '1, 32'h1);
    wr(W, 12'hB80, 32'd7);
    rd("mcycle_wrhi_hi", 12'hB80, '1, 32'd7);
    rd("mcycle_wrhi_lo", 12'hB00, '1, 32'h0);

    // minstret override, increment and carry
    instret = 1'b1;
    wr(W, 12'hB02, 32'hFFFF_FFFE);
    rd("minstret_wr", 12'hB02, '1, 32'hFFFF_FFFE);
    tick();
    rd("minstret_inc", 12'hB02, '1, 32'hFFFF_FFFF);
    tick();
    instret = 1'b0;
    rd("minstret_wrap_lo", 12'hB02, '1, 32'h0);
    rd("minstret_carry_hi", 12'hB82, '1, 32'h1);
    tick();
    rd("minstret_idle", 12'hB02, '1, 32'h0);

    // asynchronous reset mid-count
    wr(S, 12'h300, 32'h8);
    wr(W, 12'h304, 32'h800);
    ext_intr = 1'b1;
    push("pre_rst_pending", K_PENDING, 32'h1, 32'h1);
    drain();
`ifdef CSR_TIMER_EN
    rd("pre_rst_mtip", 12'h344, 32'h80, 32'h80);
`endif
    #20;
    rst = 1'b1;
    push("rst_mid_pending", K_PENDING, 32'h1, 32'h0);
    push("rst_mid_o_mepc", K_MEPC, '1, 32'h0);
    push("rst_mid_o_mtvec", K_MTVEC, '1, MTVEC_RST_P);
    drain();
    rd("rst_mid_mcycle", 12'hB00, '1, 32'h0);
    rd("rst_mid_mstatus", 12'h300, '1, 32'h0000_1800);
`ifdef CSR_TIMER_EN
    rd("rst_mid_mtime", 12'h7C0, '1, 32'h0);
    rd("rst_mid_mtip", 12'h344, 32'h80, 32'h0);
    rd("rst_mid_mtimecmp", 12'h7C2, '1, 32'hFFFF_FFFF);
`endif
    ext_intr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    rd("post_rst_mcycle0", 12'hB00, '1, 32'h0);
    tick();
    rd("post_rst_mcycle1", 12'hB00, '1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
